// File: rtl/ccsds_spi_frame_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : ccsds_spi_frame_fetcher
// Description : AXI4-Lite master that drives an AXI Quad SPI slave, collects
//               CADU_BYTES bytes from its RX FIFO into a frame and hands it on.
// Revision    : 1.0 - initial release
// ============================================================================
module ccsds_spi_frame_fetcher #(
    parameter int          CADU_BYTES    = 4,
    parameter logic [31:0] SPI_BASE_ADDR = 32'h44A0_0000,
    parameter int          POLL_TIMEOUT  = 1024,
    parameter logic [7:0]  RSP_START     = 8'h69,
    parameter logic [7:0]  RSP_OKAY      = 8'h34,
    parameter logic [7:0]  CMD_RST       = 8'h22
) (
    input  logic                    m00_axi_aclk,
    input  logic                    m00_axi_aresetn,
    output logic [31:0]             m00_axi_awaddr,
    output logic [2:0]              m00_axi_awprot,
    output logic                    m00_axi_awvalid,
    input  logic                    m00_axi_awready,
    output logic [31:0]             m00_axi_wdata,
    output logic [3:0]              m00_axi_wstrb,
    output logic                    m00_axi_wvalid,
    input  logic                    m00_axi_wready,
    input  logic [1:0]              m00_axi_bresp,
    input  logic                    m00_axi_bvalid,
    output logic                    m00_axi_bready,
    output logic [31:0]             m00_axi_araddr,
    output logic [2:0]              m00_axi_arprot,
    output logic                    m00_axi_arvalid,
    input  logic                    m00_axi_arready,
    input  logic [31:0]             m00_axi_rdata,
    input  logic [1:0]              m00_axi_rresp,
    input  logic                    m00_axi_rvalid,
    output logic                    m00_axi_rready,
    output logic [CADU_BYTES*8-1:0] frame_o,
    output logic                    frame_valid_o,
    input  logic                    frame_ready_i,
    output logic [3:0]              fsm_state_o,
    output logic                    timeout_o,
    output logic                    bus_err_o
);

    localparam int c_FRAME_W = CADU_BYTES * 8;
    localparam int c_BYTE_W  = $clog2(CADU_BYTES + 1);
    localparam int c_POLL_W  = $clog2(POLL_TIMEOUT + 1);

    localparam logic [c_BYTE_W-1:0] c_LAST_BYTE = c_BYTE_W'(CADU_BYTES - 1);
    localparam logic [c_BYTE_W-1:0] c_BYTE_MAX  = c_BYTE_W'(CADU_BYTES);
    localparam logic [c_POLL_W-1:0] c_POLL_MAX  = c_POLL_W'(POLL_TIMEOUT);

    localparam logic [31:0] c_ADDR_SPICR  = SPI_BASE_ADDR + 32'h60;
    localparam logic [31:0] c_ADDR_IPIER  = SPI_BASE_ADDR + 32'h28;
    localparam logic [31:0] c_ADDR_DGIER  = SPI_BASE_ADDR + 32'h1C;
    localparam logic [31:0] c_ADDR_SPISR  = SPI_BASE_ADDR + 32'h64;
    localparam logic [31:0] c_ADDR_SPIDTR = SPI_BASE_ADDR + 32'h68;
    localparam logic [31:0] c_ADDR_SPIDRR = SPI_BASE_ADDR + 32'h6C;

    typedef enum logic [3:0] {
        ST_INIT_CR    = 4'd0,
        ST_INIT_IPIER = 4'd1,
        ST_INIT_DGIER = 4'd2,
        ST_SEND_START = 4'd3,
        ST_POLL_SR    = 4'd4,
        ST_READ_DRR   = 4'd5,
        ST_FRAME_OUT  = 4'd6,
        ST_SEND_ACK   = 4'd7,
        ST_FIFO_RST   = 4'd8
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                 r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic [31:0]          r_awaddr, r_wdata, r_araddr;
    logic [c_FRAME_W-1:0] r_frame;
    logic                 r_frame_valid;
    logic                 r_timeout;
    logic                 r_bus_err;
    logic [c_BYTE_W-1:0]  r_byte_cnt;
    logic [c_POLL_W-1:0]  r_poll_cnt;

    logic                 w_idle, w_wr_done, w_rd_done;
    logic                 w_start_wr, w_start_rd;
    logic [31:0]          w_addr, w_data;
    logic                 w_shift, w_inc_byte, w_clr_cnt, w_inc_poll, w_clr_poll, w_timeout;
    logic [c_POLL_W-1:0]  w_poll_inc;
    logic [7:0]           w_rx_byte;
    logic [c_FRAME_W-1:0] w_frame_shifted;
    logic                 w_unused_rdata;

    assign w_idle     = !(r_awvalid || r_wvalid || r_bready || r_arvalid || r_rready);
    assign w_wr_done  = r_bready && m00_axi_bvalid;
    assign w_rd_done  = r_rready && m00_axi_rvalid;
    assign w_rx_byte  = m00_axi_rdata[7:0];
    assign w_poll_inc = (r_poll_cnt == c_POLL_MAX) ? r_poll_cnt : r_poll_cnt + 1'b1;
    assign w_unused_rdata = &{1'b0, m00_axi_rdata[31:8]};

    // New bytes enter at the LSB end so the first byte ends up in the MSBs.
    generate
        if (CADU_BYTES == 1) begin : g_shift_single
            assign w_frame_shifted = w_rx_byte;
        end else begin : g_shift_multi
            assign w_frame_shifted = {r_frame[c_FRAME_W-9:0], w_rx_byte};
        end
    endgenerate

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            r_state <= ST_INIT_CR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_start_wr = 1'b0;
        w_start_rd = 1'b0;
        w_addr     = c_ADDR_SPICR;
        w_data     = 32'h0000_0182;
        w_shift    = 1'b0;
        w_inc_byte = 1'b0;
        w_clr_cnt  = 1'b0;
        w_inc_poll = 1'b0;
        w_clr_poll = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            ST_INIT_CR: begin
                w_start_wr = w_idle;
                if (w_wr_done) w_next = ST_INIT_IPIER;
            end
            ST_INIT_IPIER: begin
                w_start_wr = w_idle;
                w_addr     = c_ADDR_IPIER;
                w_data     = 32'h0000_0100;
                if (w_wr_done) w_next = ST_INIT_DGIER;
            end
            ST_INIT_DGIER: begin
                w_start_wr = w_idle;
                w_addr     = c_ADDR_DGIER;
                w_data     = 32'h8000_0000;
                if (w_wr_done) w_next = ST_SEND_START;
            end
            ST_SEND_START: begin
                w_start_wr = w_idle;
                w_addr     = c_ADDR_SPIDTR;
                w_data     = {24'h0, RSP_START};
                w_clr_cnt  = 1'b1;
                if (w_wr_done) w_next = ST_POLL_SR;
            end
            ST_POLL_SR: begin
                w_start_rd = w_idle;
                w_addr     = c_ADDR_SPISR;
                if (w_rd_done) begin
                    if (m00_axi_rdata[0]) begin
                        w_inc_poll = 1'b1;
                        if (w_poll_inc == c_POLL_MAX) begin
                            w_timeout = 1'b1;
                            w_next    = ST_FIFO_RST;
                        end
                    end else begin
                        w_clr_poll = 1'b1;
                        w_next     = ST_READ_DRR;
                    end
                end
            end
            ST_READ_DRR: begin
                w_start_rd = w_idle;
                w_addr     = c_ADDR_SPIDRR;
                if (w_rd_done) begin
                    // A restart command is only honoured as the first byte of a frame.
                    if ((r_byte_cnt == '0) && (w_rx_byte == CMD_RST)) begin
                        w_next = ST_FIFO_RST;
                    end else begin
                        w_shift    = 1'b1;
                        w_inc_byte = 1'b1;
                        w_next     = (r_byte_cnt == c_LAST_BYTE) ? ST_FRAME_OUT : ST_POLL_SR;
                    end
                end
            end
            ST_FRAME_OUT: begin
                if (r_frame_valid && frame_ready_i) w_next = ST_SEND_ACK;
            end
            ST_SEND_ACK: begin
                w_start_wr = w_idle;
                w_addr     = c_ADDR_SPIDTR;
                w_data     = {24'h0, RSP_OKAY};
                if (w_wr_done) begin
                    w_clr_cnt = 1'b1;
                    w_next    = ST_POLL_SR;
                end
            end
            ST_FIFO_RST: begin
                w_start_wr = w_idle;
                w_data     = 32'h0000_01E2;
                if (w_wr_done) w_next = ST_SEND_START;
            end
            default: begin
                w_next = ST_INIT_CR;
            end
        endcase
    end

    // Single-outstanding AXI engine: a write completes when B is accepted,
    // a read when R is accepted.
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_araddr  <= '0;
        end else begin
            if (w_start_wr) begin
                r_awaddr  <= w_addr;
                r_wdata   <= w_data;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
            end else begin
                if (r_awvalid && m00_axi_awready) r_awvalid <= 1'b0;
                if (r_wvalid && m00_axi_wready)   r_wvalid  <= 1'b0;
                if ((r_awvalid || r_wvalid) &&
                    !(r_awvalid && !m00_axi_awready) &&
                    !(r_wvalid && !m00_axi_wready)) begin
                    r_bready <= 1'b1;
                end
                if (w_wr_done) r_bready <= 1'b0;
            end
            if (w_start_rd) begin
                r_araddr  <= w_addr;
                r_arvalid <= 1'b1;
            end else begin
                if (r_arvalid && m00_axi_arready) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                end
                if (w_rd_done) r_rready <= 1'b0;
            end
        end
    end

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            r_frame       <= '0;
            r_frame_valid <= 1'b0;
            r_timeout     <= 1'b0;
            r_bus_err     <= 1'b0;
            r_byte_cnt    <= '0;
            r_poll_cnt    <= '0;
        end else begin
            if (w_shift) r_frame <= w_frame_shifted;
            r_frame_valid <= (w_next == ST_FRAME_OUT);
            r_timeout     <= w_timeout;
            if ((w_wr_done && (m00_axi_bresp != 2'b00)) ||
                (w_rd_done && (m00_axi_rresp != 2'b00))) begin
                r_bus_err <= 1'b1;
            end
            if (w_clr_cnt) begin
                r_byte_cnt <= '0;
            end else if (w_inc_byte && (r_byte_cnt != c_BYTE_MAX)) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
            if (w_clr_cnt || w_clr_poll) begin
                r_poll_cnt <= '0;
            end else if (w_inc_poll) begin
                r_poll_cnt <= w_poll_inc;
            end
        end
    end

    assign m00_axi_awaddr  = r_awaddr;
    assign m00_axi_awprot  = 3'b000;
    assign m00_axi_awvalid = r_awvalid;
    assign m00_axi_wdata   = r_wdata;
    assign m00_axi_wstrb   = 4'hF;
    assign m00_axi_wvalid  = r_wvalid;
    assign m00_axi_bready  = r_bready;
    assign m00_axi_araddr  = r_araddr;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arvalid = r_arvalid;
    assign m00_axi_rready  = r_rready;
    assign frame_o         = r_frame;
    assign frame_valid_o   = r_frame_valid;
    assign fsm_state_o     = r_state;
    assign timeout_o       = r_timeout;
    assign bus_err_o       = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_ccsds_spi_frame_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccsds_spi_frame_fetcher
// Description : Directed bench with a reactive AXI4-Lite SPI slave model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccsds_spi_frame_fetcher;

    localparam logic [31:0] c_SPICR  = 32'h44A0_0060;
    localparam logic [31:0] c_IPIER  = 32'h44A0_0028;
    localparam logic [31:0] c_DGIER  = 32'h44A0_001C;
    localparam logic [31:0] c_SPISR  = 32'h44A0_0064;
    localparam logic [31:0] c_SPIDTR = 32'h44A0_0068;
    localparam logic [31:0] c_SPIDRR = 32'h44A0_006C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr, wdata, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [31:0] rdata = 32'h0;
    logic [31:0] frame;
    logic        frame_valid, frame_ready = 1'b0;
    logic [3:0]  fsm_state;
    logic        timeout, bus_err;

    int n_cmp = 0;
    int n_mis = 0;

    logic [63:0] wr_q[$];
    logic [31:0] sr_q[$];
    logic [31:0] drr_q[$];
    logic [31:0] cur_aw, cur_w, cur_ar;
    logic        err_arm = 1'b0;
    int          sr_reads = 0;
    int          to_pulses = 0;
    int          to_reads = 0;

    always #5 clk = ~clk;

    ccsds_spi_frame_fetcher #(
        .CADU_BYTES   (4),
        .POLL_TIMEOUT (8)
    ) dut (
        .m00_axi_aclk    (clk),
        .m00_axi_aresetn (rst_n),
        .m00_axi_awaddr  (awaddr),
        .m00_axi_awprot  (awprot),
        .m00_axi_awvalid (awvalid),
        .m00_axi_awready (awready),
        .m00_axi_wdata   (wdata),
        .m00_axi_wstrb   (wstrb),
        .m00_axi_wvalid  (wvalid),
        .m00_axi_wready  (wready),
        .m00_axi_bresp   (bresp),
        .m00_axi_bvalid  (bvalid),
        .m00_axi_bready  (bready),
        .m00_axi_araddr  (araddr),
        .m00_axi_arprot  (arprot),
        .m00_axi_arvalid (arvalid),
        .m00_axi_arready (arready),
        .m00_axi_rdata   (rdata),
        .m00_axi_rresp   (rresp),
        .m00_axi_rvalid  (rvalid),
        .m00_axi_rready  (rready),
        .frame_o         (frame),
        .frame_valid_o   (frame_valid),
        .frame_ready_i   (frame_ready),
        .fsm_state_o     (fsm_state),
        .timeout_o       (timeout),
        .bus_err_o       (bus_err)
    );

    // Slave answers every request with a one-cycle ready and the next-cycle response.
    always @(negedge clk) begin
        if (!rst_n) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            arready = 1'b0; rvalid = 1'b0; bresp = 2'b00;
        end else begin
            if (awvalid && !awready) begin awready = 1'b1; cur_aw = awaddr; end
            else awready = 1'b0;
            if (wvalid && !wready) begin wready = 1'b1; cur_w = wdata; end
            else wready = 1'b0;
            if (bready && !bvalid) begin
                bvalid = 1'b1;
                bresp  = (err_arm && cur_aw == c_SPIDTR) ? 2'b10 : 2'b00;
                if (err_arm && cur_aw == c_SPIDTR) err_arm = 1'b0;
                wr_q.push_back({cur_aw, cur_w});
            end else begin
                bvalid = 1'b0;
                bresp  = 2'b00;
            end
            if (arvalid && !arready) begin arready = 1'b1; cur_ar = araddr; end
            else arready = 1'b0;
            if (rready && !rvalid) begin
                rvalid = 1'b1;
                if (cur_ar == c_SPISR) begin
                    rdata = (sr_q.size() != 0) ? sr_q.pop_front() : 32'h1;
                    sr_reads++;
                end else if (cur_ar == c_SPIDRR) begin
                    rdata = (drr_q.size() != 0) ? drr_q.pop_front() : 32'h0;
                end else begin
                    rdata = 32'h0;
                end
            end else begin
                rvalid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (timeout) begin
            to_pulses++;
            to_reads = sr_reads;
        end
    end

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_wr(input string tag, input logic [31:0] a, input logic [31:0] d);
        int          n;
        logic        seen;
        logic [63:0] rec;
        n = 0;
        while (wr_q.size() == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        seen = (wr_q.size() != 0);
        check_value({tag, "_seen"}, seen, 1);
        if (seen) begin
            rec = wr_q.pop_front();
            check_value({tag, "_addr"}, rec[63:32], a);
            check_value({tag, "_data"}, rec[31:0], d);
        end
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        while (frame_valid !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_value({tag, "_valid"}, frame_valid, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_value({tag, "_ch"}, {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        check_value({tag, "_addr"}, {awaddr, araddr}, 64'h0);
        check_value({tag, "_wdata"}, wdata, 32'h0);
        check_value({tag, "_frame"}, frame, 32'h0);
        check_value({tag, "_flags"}, {frame_valid, timeout, bus_err}, 3'b0);
        check_value({tag, "_state"}, fsm_state, 4'd0);
    endtask

    initial begin
        int unstable;
        int n;
        sr_q  = '{32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
        drr_q = '{32'h4F, 32'h00, 32'h4F, 32'h00};
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // T1: configuration sequence and start request
        expect_wr("t1_cr",    c_SPICR,  32'h182);
        expect_wr("t1_ipier", c_IPIER,  32'h100);
        expect_wr("t1_dgier", c_DGIER,  32'h8000_0000);
        expect_wr("t1_start", c_SPIDTR, 32'h69);

        // T2: two empty polls then four bytes
        wait_frame("t2");
        check_value("t2_frame", frame, 32'h4F00_4F00);
        check_value("t2_state", fsm_state, 4'd6);

        // T3: back-pressure then handshake and acknowledge
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (frame !== 32'h4F00_4F00 || frame_valid !== 1'b1) unstable++;
        end
        check_value("t3_stable", unstable, 0);
        check_value("t3_no_wr", wr_q.size(), 0);
        sr_reads = 0;
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        check_value("t3_drop", frame_valid, 0);
        expect_wr("t3_ack", c_SPIDTR, 32'h34);
        check_value("t3_bus_err", bus_err, 0);

        // T4: SPISR stays empty until the poll budget runs out
        n = 0;
        while (to_pulses == 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_value("t4_pulse", to_pulses, 1);
        check_value("t4_polls", to_reads, 8);
        sr_q  = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        drr_q = '{32'h22, 32'h11, 32'h22, 32'h33, 32'h44};
        expect_wr("t4_fiforst", c_SPICR,  32'h1E2);
        expect_wr("t4_start",   c_SPIDTR, 32'h69);
        check_value("t4_width", to_pulses, 1);

        // T5: restart command as first byte, then a frame containing that byte later
        expect_wr("t5_fiforst", c_SPICR,  32'h1E2);
        expect_wr("t5_start",   c_SPIDTR, 32'h69);
        check_value("t5_keep", frame, 32'h4F00_4F00);
        check_value("t5_novalid", frame_valid, 0);
        wait_frame("t5");
        check_value("t5_frame", frame, 32'h1122_3344);

        // T6: error response on the acknowledge, then reset mid-read
        err_arm = 1'b1;
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        expect_wr("t6_ack", c_SPIDTR, 32'h34);
        repeat (3) @(negedge clk);
        check_value("t6_bus_err", bus_err, 1);
        n = 0;
        while (rready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_value("t6_rready", rready, 1);
        check_value("t6_state", fsm_state, 4'd4);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("t6_rst");
        repeat (2) @(negedge clk);
        wr_q.delete();
        sr_q.delete();
        drr_q.delete();
        rst_n = 1'b1;
        expect_wr("t6_cr", c_SPICR, 32'h182);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
